rv32_multicycle_ctrl: RTL and testbench
=======================================

Name: rv32_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback.
- It issues req/ack handshakes to instruction and data memory, generates PC/IR/register-file write strobes, and resolves branches from ALU flags.
- It sits beside the combinational instruction decoder, which still supplies ALU_control, operand selects and B_H_W/sign.
- It traps on illegal opcodes and on memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: maximum counter value while waiting for imem_ack/dmem_ack before trapping.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  permits starting a new instruction
- OPcode  in  7  instruction bits [6:0] from IR
- Fun1  in  3  instruction funct3 from IR
- alu_zero  in  1  ALU result == 0
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU/GE/GEU outcome)
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction register
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- rf_we  out  1  register file write strobe
- pc_write  out  1  update PC
- pc_src  out  2  00 pc+4, 01 branch target, 10 jal target, 11 jalr target
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky trap flag
- trap_cause  out  2  00 none, 01 illegal instr, 10 imem timeout, 11 dmem timeout
- state  out  3  current state encoding
- instret  out  32  retired instruction count

Behaviour:
- State encoding: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 111.
- Reset (rst_n low, asynchronous): state=IDLE, trap=0, trap_cause=00, instret=0, wait counter=0. All strobes and requests are decoded from state, so they are 0 in IDLE.

Per-state behaviour:
- IDLE: moves to FETCH when run=1; otherwise stays.
- FETCH: imem_req=1. When imem_ack=1: ir_write=1 that cycle, then DECODE.
- DECODE: one cycle for the register file read.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode, or a branch (1100011) with Fun1 010 or 011, goes to TRAP with cause 01. Otherwise goes to EXEC.
- EXEC:
  - Branch: pc_write=1; retire=1; next state FETCH if run, else IDLE. pc_src is 01 if taken, else 00.
  - Branch taken rule: BEQ: alu_zero; BNE: !alu_zero; BLT, BGE, BLTU, BGEU: alu_lsb.
  - Load (0000011) or store (0100011): go to MEM.
  - All other opcodes: go to WB.
- MEM: dmem_req=1; dmem_we=1 when the opcode is a store. When dmem_ack=1:
  - Store: pc_write=1, pc_src=00, retire=1; next state FETCH if run, else IDLE.
  - Load: go to WB.
- WB: rf_we=1; pc_write=1; retire=1; next state FETCH if run, else IDLE. pc_src is 10 for jal, 11 for jalr, otherwise 00.
- TRAP: all requests and strobes are 0. Only reset exits.
- run only gates instruction start. Deasserting run mid-instruction does not abort the instruction.

Wait counter and timeouts:
- Cleared on entry to FETCH or MEM.
- Increments each cycle in FETCH/MEM without ack.
- Ack in a cycle where counter==MEM_TIMEOUT is accepted; ack wins over timeout.
- No ack with counter==MEM_TIMEOUT: go to TRAP, cause 10 from FETCH or 11 from MEM.
- Maximum wait is therefore MEM_TIMEOUT+1 cycles.

instret and latency:
- instret increments on each retire; wraps from 0xFFFFFFFF to 0.
- Latency with zero-wait memory (FETCH to retire cycle): ALU/jal/jalr/lui/auipc 4 cycles; branch 3; store 4; load 5.
- A request stays high until its ack. An ack arriving in any other state is ignored.
- Reset asserted mid-MEM: the request drops immediately, and a dmem_ack that arrives later is ignored.

Test Plan:
- run=1, zero-wait acks, IR ADDI (0010011/000): states 001,010,011,101. In the WB cycle: rf_we=1, pc_write=1, pc_src=00, retire=1. instret=1 after that cycle.
- BEQ with alu_zero=1 gives pc_src=01 in EXEC. BNE with alu_zero=1 gives pc_src=00. BGEU with alu_lsb=1 gives pc_src=01. No rf_we pulse in any of these; retire at cycle 3.
- LW with dmem_ack 3 cycles after dmem_req rises: dmem_req is held 4 cycles with dmem_we=0, then WB with rf_we=1. SW: dmem_we=1, no rf_we, retire in the ack cycle.
- OPcode 0000000, or branch Fun1 010: TRAP (state=111), trap=1, cause=01. imem_req stays 0 until rst_n pulses low, after which state=000 and trap=0.
- MEM_TIMEOUT=4, imem_ack held 0: TRAP with cause 10 after 5 FETCH cycles. Repeat with the ack exactly on the 5th cycle: no trap, goes to DECODE.
- Deassert run during EXEC of an ADD: the instruction retires and state goes to IDLE. Assert rst_n low during MEM: dmem_req drops asynchronously and instret is 0.

Source files
------------

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle sequencer for an RV32I datapath: fetch/decode/execute/memory/writeback,
// memory handshakes with timeout traps, branch resolution and retired-instruction count.
module rv32_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  OPcode,
    input  logic [2:0]  Fun1,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StFetch  = 3'b001,
        StDecode = 3'b010,
        StExec   = 3'b011,
        StMem    = 3'b100,
        StWb     = 3'b101,
        StTrap   = 3'b111
    } state_e;

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MEM_TIMEOUT);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic [31:0]      instret_q;

    logic is_branch, is_load, is_store, is_jal, is_jalr, legal, taken, timeout;

    always_comb begin
        is_branch = (OPcode == OpBranch);
        is_load   = (OPcode == OpLoad);
        is_store  = (OPcode == OpStore);
        is_jal    = (OPcode == OpJal);
        is_jalr   = (OPcode == OpJalr);
        legal     = (OPcode inside {OpReg, OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr,
                                    OpLui, OpAuipc}) &&
                    !(is_branch && (Fun1 inside {3'b010, 3'b011}));
        // BEQ/BNE use the zero flag; the four compare branches use the ALU compare bit.
        unique case (Fun1)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            default: taken = alu_lsb;
        endcase
        timeout = (cnt_q == CntMax);
    end

    // Strobes are decoded from the current state plus same-cycle acks and ALU flags.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_write = 1'b0;
        pc_src   = 2'b00;
        retire   = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
            end
            StExec: begin
                if (is_branch) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    pc_src   = taken ? 2'b01 : 2'b00;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_write = is_store && dmem_ack;
                retire   = is_store && dmem_ack;
            end
            StWb: begin
                rf_we    = 1'b1;
                pc_write = 1'b1;
                retire   = 1'b1;
                pc_src   = is_jal ? 2'b10 : (is_jalr ? 2'b11 : 2'b00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            instret_q <= 32'd0;
        end else begin
            if (retire) instret_q <= instret_q + 32'd1;
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StFetch;
                        cnt_q   <= '0;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDecode: begin
                    if (legal) begin
                        state_q <= StExec;
                    end else begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b01;
                    end
                end
                StExec: begin
                    if (is_branch) begin
                        state_q <= run ? StFetch : StIdle;
                        cnt_q   <= '0;
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (dmem_ack) begin
                        if (is_store) begin
                            state_q <= run ? StFetch : StIdle;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (timeout) begin
                        state_q <= StTrap;
                        trap_q  <= 1'b1;
                        cause_q <= 2'b11;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StWb: begin
                    state_q <= run ? StFetch : StIdle;
                    cnt_q   <= '0;
                end
                StTrap: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: directed scenarios plus random instruction streams, each
// expanded into an expected per-cycle trace from instruction class and memory wait counts.
module tb_rv32_multicycle_ctrl;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  OPcode = 7'b0;
    logic [2:0]  Fun1 = 3'b0;
    logic        alu_zero = 1'b0;
    logic        alu_lsb = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, retire, trap;
    logic [1:0]  pc_src, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    rv32_multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .OPcode(OPcode), .Fun1(Fun1),
        .alu_zero(alu_zero), .alu_lsb(alu_lsb), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_write(pc_write), .pc_src(pc_src), .retire(retire), .trap(trap),
        .trap_cause(trap_cause), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] count_m = 32'd0;
    logic [14:0] obs;
    assign obs = {state, imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, pc_src,
                  retire, trap, trap_cause};

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000,
                             7'b1111111};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [14:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                       input logic dreq, input logic dwe, input logic rfwe,
                                       input logic pcw, input logic [1:0] pcs, input logic ret);
        return {st, ireq, irw, dreq, dwe, rfwe, pcw, pcs, ret, 3'b000};
    endfunction

    task automatic check(input string tag, input logic [14:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
        checks++;
        assert (instret === count_m) else begin
            errors++;
            $error("FAIL %s instret: observed %0d expected %0d", tag, instret, count_m);
        end
    endtask

    // Inputs are driven just after the rising edge and outputs compared on the falling edge.
    task automatic cyc(input string tag, input logic ia, input logic da, input logic [14:0] exp_v);
        imem_ack = ia;
        dmem_ack = da;
        @(negedge clk);
        check(tag, exp_v);
        @(posedge clk);
        #1;
        if (exp_v[3]) count_m = count_m + 32'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        count_m = 32'd0;
        check("reset", 15'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_idle();
        run = 1'b0;
        cyc("idle_hold", rb(), rb(), 15'b0);
        run = 1'b1;
        cyc("idle_go", rb(), rb(), 15'b0);
    endtask

    task automatic expect_trap(input logic [1:0] cause);
        run = 1'b1;
        for (int i = 0; i < 3; i++) cyc("trap", 1'b1, 1'b1, {3'b111, 9'b0, 1'b1, cause});
        do_reset();
        start_idle();
    endtask

    // Expected trace of one instruction given its class and memory wait counts (>T = timeout).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic az,
                             input logic al, input int wi, input int wd, input logic run_next);
        logic st, br, lg, tk;
        logic [1:0] pcs;
        st = (op == 7'b0100011);
        br = (op == 7'b1100011);
        lg = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111}) &&
             !(br && (f3 == 3'b010 || f3 == 3'b011));
        OPcode = op; Fun1 = f3; alu_zero = az; alu_lsb = al; run = 1'b1;
        for (int k = 0; k <= int'(T); k++) begin
            if (k == wi) begin
                cyc("fetch_ack", 1'b1, rb(), mk(3'b001, 1, 1, 0, 0, 0, 0, 2'b00, 0));
                break;
            end
            cyc("fetch_wait", 1'b0, rb(), mk(3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        end
        if (wi > int'(T)) begin expect_trap(2'b10); return; end
        cyc("decode", rb(), rb(), mk(3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        if (!lg) begin expect_trap(2'b01); return; end
        run = run_next;
        if (br) begin
            if (f3 == 3'b000)      tk = az;
            else if (f3 == 3'b001) tk = !az;
            else                   tk = al;
            cyc("exec_branch", rb(), rb(), mk(3'b011, 0, 0, 0, 0, 0, 1, tk ? 2'b01 : 2'b00, 1));
        end else begin
            cyc("exec", rb(), rb(), mk(3'b011, 0, 0, 0, 0, 0, 0, 2'b00, 0));
            if (op == 7'b0000011 || st) begin
                for (int k = 0; k <= int'(T); k++) begin
                    if (k == wd) begin
                        cyc("mem_ack", rb(), 1'b1, mk(3'b100, 0, 0, 1, st, 0, st, 2'b00, st));
                        break;
                    end
                    cyc("mem_wait", rb(), 1'b0, mk(3'b100, 0, 0, 1, st, 0, 0, 2'b00, 0));
                end
                if (wd > int'(T)) begin expect_trap(2'b11); return; end
            end
            if (!st) begin
                pcs = (op == 7'b1101111) ? 2'b10 : ((op == 7'b1100111) ? 2'b11 : 2'b00);
                cyc("wb", rb(), rb(), mk(3'b101, 0, 0, 0, 0, 1, 1, pcs, 1));
            end
        end
        if (!run_next) start_idle();
        run = 1'b1;
    endtask

    int wi_r, wd_r;

    initial begin
        do_reset();
        start_idle();
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);  // ADDI
        run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, 0, 0, 1'b1);  // BEQ taken
        run_instr(7'b1100011, 3'b001, 1'b1, 1'b0, 0, 0, 1'b1);  // BNE not taken
        run_instr(7'b1100011, 3'b111, 1'b0, 1'b1, 0, 0, 1'b1);  // BGEU taken
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3, 1'b1);  // LW, late ack
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1);  // SW
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);  // ADD, run drops in EXEC
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1, 0, 1'b1);  // JAL
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);  // JALR
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 4, 0, 1'b1);  // ack on last allowed cycle
        run_instr(7'b0100011, 3'b000, 1'b0, 1'b0, 0, 4, 1'b1);  // store ack on last cycle
        // Reset in the middle of a store's MEM wait; a later ack must be ignored.
        OPcode = 7'b0100011; Fun1 = 3'b010; run = 1'b1;
        cyc("rm_fetch", 1'b1, 1'b0, mk(3'b001, 1, 1, 0, 0, 0, 0, 2'b00, 0));
        cyc("rm_decode", 1'b0, 1'b0, mk(3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        cyc("rm_exec", 1'b0, 1'b0, mk(3'b011, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        cyc("rm_mem", 1'b0, 1'b0, mk(3'b100, 0, 0, 1, 1, 0, 0, 2'b00, 0));
        do_reset();
        run = 1'b0;
        cyc("rm_late_ack", 1'b0, 1'b1, 15'b0);
        cyc("rm_late_ack2", 1'b0, 1'b1, 15'b0);
        start_idle();
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 1'b1);  // illegal opcode
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1);  // illegal branch funct3
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 5, 0, 1'b1);  // imem timeout
        run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, 0, 5, 1'b1);  // dmem timeout
        for (int n = 0; n < 80; n++) begin
            wi_r = ($urandom_range(0, 9) == 0) ? int'(T) + 1 : int'($urandom_range(0, T));
            wd_r = ($urandom_range(0, 9) == 0) ? int'(T) + 1 : int'($urandom_range(0, T));
            run_instr(ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), rb(), rb(),
                      wi_r, wd_r, ($urandom_range(0, 3) != 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
